btn_conditioner: RTL and testbench
==================================

Name: btn_conditioner

Overview:
- Input-conditioning stage between the raw `ui_in` button pins and the game FSM's `btn_sync`/lockout logic.
- Per button: synchronises the asynchronous input, debounces it, and produces a stable level plus one-cycle press and release pulses.
- Also keeps a saturating count of accepted presses for bring-up and diagnostics.
- The game FSM consumes `btn_level` in place of raw buttons; the RNG/pattern entropy may tap `btn_press`.

Parameters:
- N_BTN, 8, number of button channels.
- SYNC_STAGES, 2, synchroniser flops per channel (legal: 2 or 3).
- DEBOUNCE_CYCLES, 1000, consecutive stable synchronised cycles needed to accept a level change (legal: 1..65535). Counter width is clog2(DEBOUNCE_CYCLES+1).
- ACTIVE_LOW, 0, 1 means a raw pin low is "pressed". Inversion is applied before the synchroniser.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  conditioning enable; low forces all channels to the released state.
- clr_count  in  1  synchronous clear of press_count.
- btn_raw  in  N_BTN  raw asynchronous button pins.
- btn_level  out  N_BTN  debounced level, 1 = pressed.
- btn_press  out  N_BTN  one-cycle pulse on an accepted press.
- btn_release  out  N_BTN  one-cycle pulse on an accepted release.
- any_press  out  1  OR of btn_press, registered in the same cycle.
- press_count  out  8  saturating total of accepted presses.

Behaviour:
- Reset (async, all registers):
  - btn_level, btn_press, btn_release, any_press, press_count = 0.
  - Synchroniser flops reset to the inactive value (0 after polarity inversion).
  - Debounce counters = 0.
- Polarity: p = btn_raw ^ {N_BTN{ACTIVE_LOW[0]}}. p feeds a SYNC_STAGES-deep flop chain per channel; s = last flop.
- Per-channel FSM (2 bits), states:
  - REL: stable released, counter 0.
  - PEND_P: s=1 seen, counting.
  - PRS: stable pressed, counter 0.
  - PEND_R: s=0 seen, counting.
- Transitions:
  - REL: s=1 -> PEND_P with counter=1. If DEBOUNCE_CYCLES==1, go directly to PRS and assert press.
  - PEND_P: s=0 -> REL, counter=0 (bounce rejected). s=1 -> counter+1; when counter+1==DEBOUNCE_CYCLES -> PRS, counter=0, btn_press=1 for one cycle.
  - PRS and PEND_R: mirror image of REL and PEND_P. Acceptance gives btn_release=1 for one cycle.
- btn_level = 1 in PRS and PEND_R; 0 in REL and PEND_P. It is registered and changes on the same edge as the pulse.
- Latency: raw held pressed from before edge 1 gives btn_level=1 and btn_press=1 after edge SYNC_STAGES+DEBOUNCE_CYCLES. Release latency is identical.
- Glitch rejection: any excursion shorter than DEBOUNCE_CYCLES synchronised cycles never changes btn_level and produces no pulse.
- press_count:
  - Each cycle, press_count <= min(255, press_count + popcount(btn_press)).
  - Use a 9-bit intermediate sum; simultaneous presses are each counted.
  - clr_count=1 sets 0 and has priority over increment in the same cycle.
  - Saturated at 255: it holds, no wrap.
- en=0:
  - Every channel FSM goes to REL with counter 0.
  - btn_level, btn_press, btn_release, any_press = 0.
  - No release pulse is emitted for channels that were pressed.
  - Synchronisers keep running; press_count holds.
- en rising with a button held: the channel debounces from REL and presses after DEBOUNCE_CYCLES cycles (synchroniser already settled).
- Channels are fully independent. No pulse is ever wider than one cycle; press and release are never both high on one channel.
- Reset asserted mid-debounce aborts immediately to the reset values above.

Test Plan:
- DEBOUNCE_CYCLES=4, SYNC_STAGES=2: btn_raw[0] 0->1 before edge 1 and held -> btn_level[0] and btn_press[0] rise after edge 6; press is high for exactly 1 cycle; any_press=1 in the same cycle; press_count=1.
- Same config: btn_raw[3] high for 3 cycles, low for 1, then held high -> no pulse during the bounce; press occurs 6 edges after the last rise; exactly one press counted.
- Pressed ch0 released with a 2-cycle glitch (1-0-0-1) -> btn_level stays 1 and there is no release pulse. A clean release gives btn_release[0] after 6 edges and btn_level=0.
- btn_raw[2], [5] and [7] rise on the same edge -> three press pulses in one cycle, press_count +3. Preload to 254 by repeated presses, then press 2 at once -> press_count = 255 and holds. clr_count together with a press -> 0.
- ACTIVE_LOW=1: pin driven 0 and held -> press after SYNC+DEBOUNCE edges. Pin idle at 1 after reset -> no pulses.
- Button held and pressed, then en=0 -> btn_level=0 next cycle with no release pulse. en=1 with the button still held -> press after 4 edges. rst_n pulsed mid-PEND_P -> all outputs 0 at once and no pulse afterwards until a full debounce completes.

Source files
------------

// File: rtl/btn_conditioner.sv
// btn_conditioner: per-button synchroniser, debouncer and press/release pulse generator with a saturating press counter
module btn_conditioner #(
    parameter int N_BTN           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int ACTIVE_LOW      = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr_count,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic             any_press,
    output logic [7:0]       press_count
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {REL, PEND_P, PRS, PEND_R} state_t;

    logic [N_BTN-1:0] sync [SYNC_STAGES];
    logic [N_BTN-1:0] s;
    logic [N_BTN-1:0] press_nxt;
    logic [8:0]       sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= '0;
        end else begin
            sync[0] <= btn_raw ^ {N_BTN{ACTIVE_LOW[0]}};
            for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
        end
    end

    assign s = sync[SYNC_STAGES-1];

    for (genvar g = 0; g < N_BTN; g++) begin : ch
        state_t        st;
        logic [CW-1:0] cnt;
        logic          lvl, prs, rel, hit;
        // stable states hold cnt=0, so hit there means a single-cycle debounce
        assign hit          = (cnt + CW'(1)) == LAST;
        assign press_nxt[g] = en && s[g] && (st == REL || st == PEND_P) && hit;
        assign btn_level[g]   = lvl;
        assign btn_press[g]   = prs;
        assign btn_release[g] = rel;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n || !en) begin
                st  <= REL;
                cnt <= '0;
                lvl <= 1'b0;
                prs <= 1'b0;
                rel <= 1'b0;
            end else begin
                prs <= 1'b0;
                rel <= 1'b0;
                if (st == REL || st == PEND_P) begin
                    if (!s[g]) begin
                        st  <= REL;
                        cnt <= '0;
                    end else if (hit) begin
                        st  <= PRS;
                        cnt <= '0;
                        lvl <= 1'b1;
                        prs <= 1'b1;
                    end else begin
                        st  <= PEND_P;
                        cnt <= cnt + CW'(1);
                    end
                end else begin
                    if (s[g]) begin
                        st  <= PRS;
                        cnt <= '0;
                    end else if (hit) begin
                        st  <= REL;
                        cnt <= '0;
                        lvl <= 1'b0;
                        rel <= 1'b1;
                    end else begin
                        st  <= PEND_R;
                        cnt <= cnt + CW'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        sum = {1'b0, press_count};
        for (int i = 0; i < N_BTN; i++) sum = sum + 9'(btn_press[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_press   <= 1'b0;
            press_count <= 8'd0;
        end else begin
            any_press   <= |press_nxt;
            press_count <= clr_count ? 8'd0 : !en ? press_count : sum[8] ? 8'hFF : sum[7:0];
        end
    end
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: table-driven, directed and random checks of btn_conditioner against a run-length reference model
module tb_btn_conditioner;
    localparam int SY = 2;
    localparam int DB = 4;

    typedef struct {
        logic [7:0] raw, lvl, prs, rel;
        logic       any;
        logic [7:0] cnt;
    } vec_t;

    logic       clk = 1'b0, rst_n = 1'b0, en = 1'b1, clr = 1'b0;
    logic [7:0] raw [2];
    logic [7:0] o_lvl [2], o_prs [2], o_rel [2], o_cnt [2];
    logic       o_any [2];
    int         n_chk = 0, n_pass = 0;

    logic [7:0] m_hist [2][SY];
    logic [7:0] m_lvl [2], m_prs [2], m_rel [2];
    logic       m_any [2];
    int         m_cnt [2];
    int         m_run [2][8];
    vec_t       tbl [19];

    always #5 clk = ~clk;

    btn_conditioner #(.N_BTN(8), .SYNC_STAGES(SY), .DEBOUNCE_CYCLES(DB), .ACTIVE_LOW(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr_count(clr), .btn_raw(raw[0]),
        .btn_level(o_lvl[0]), .btn_press(o_prs[0]), .btn_release(o_rel[0]),
        .any_press(o_any[0]), .press_count(o_cnt[0]));

    btn_conditioner #(.N_BTN(8), .SYNC_STAGES(SY), .DEBOUNCE_CYCLES(DB), .ACTIVE_LOW(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr_count(clr), .btn_raw(raw[1]),
        .btn_level(o_lvl[1]), .btn_press(o_prs[1]), .btn_release(o_rel[1]),
        .any_press(o_any[1]), .press_count(o_cnt[1]));

    function automatic void m_reset();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < SY; k++) m_hist[d][k] = 8'h00;
            m_lvl[d] = 8'h00;
            m_prs[d] = 8'h00;
            m_rel[d] = 8'h00;
            m_any[d] = 1'b0;
            m_cnt[d] = 0;
            for (int i = 0; i < 8; i++) m_run[d][i] = 0;
        end
    endfunction

    // A level flips once DB consecutive synchronised samples disagree with it
    function automatic void m_step();
        logic [7:0] p, s;
        for (int d = 0; d < 2; d++) begin
            p = raw[d] ^ (d == 1 ? 8'hFF : 8'h00);
            s = m_hist[d][SY-1];
            for (int k = SY - 1; k > 0; k--) m_hist[d][k] = m_hist[d][k-1];
            m_hist[d][0] = p;
            if (clr) m_cnt[d] = 0;
            else if (en) m_cnt[d] = (m_cnt[d] + $countones(m_prs[d]) > 255) ? 255 : m_cnt[d] + $countones(m_prs[d]);
            m_prs[d] = 8'h00;
            m_rel[d] = 8'h00;
            for (int i = 0; i < 8; i++) begin
                if (!en) begin
                    m_lvl[d][i] = 1'b0;
                    m_run[d][i] = 0;
                end else if (s[i] != m_lvl[d][i]) begin
                    m_run[d][i]++;
                    if (m_run[d][i] == DB) begin
                        m_lvl[d][i] = s[i];
                        m_run[d][i] = 0;
                        if (s[i]) m_prs[d][i] = 1'b1;
                        else m_rel[d][i] = 1'b1;
                    end
                end else m_run[d][i] = 0;
            end
            m_any[d] = |m_prs[d];
        end
    endfunction

    function automatic void chk(string nm, int d, logic [7:0] a, logic [7:0] e);
        n_chk++;
        if (a === e) n_pass++;
        else $display("FAIL %s dut%0d actual=%0h expected=%0h", nm, d, a, e);
    endfunction

    function automatic void check_model();
        for (int d = 0; d < 2; d++) begin
            chk("level", d, o_lvl[d], m_lvl[d]);
            chk("press", d, o_prs[d], m_prs[d]);
            chk("release", d, o_rel[d], m_rel[d]);
            chk("any_press", d, {7'b0, o_any[d]}, {7'b0, m_any[d]});
            chk("press_count", d, o_cnt[d], 8'(m_cnt[d]));
        end
    endfunction

    task automatic tick(input logic [7:0] r0, input logic [7:0] r1);
        raw[0] = r0;
        raw[1] = r1;
        @(posedge clk);
        if (!rst_n) m_reset();
        else m_step();
        #1;
        check_model();
    endtask

    task automatic t(input logic [7:0] r);
        tick(r, ~r);
    endtask

    task automatic wait_pulse(input logic [7:0] r, input bit rel, input logic [7:0] mask, input int exp_n, input string nm);
        int k;
        k = 0;
        do begin
            t(r);
            k++;
        end while ((rel ? o_rel[0] : o_prs[0]) == 8'h00 && k < 20);
        chk({nm, "_latency"}, 0, 8'(k), 8'(exp_n));
        chk({nm, "_mask"}, 0, rel ? o_rel[0] : o_prs[0], mask);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [7:0] r0, r1;
        for (int j = 0; j < 19; j++) begin
            int e;
            e = j + 1;
            tbl[j].raw = (e >= 9 && e != 12) ? 8'h09 : 8'h01;
            tbl[j].lvl = e < 6 ? 8'h00 : e < 18 ? 8'h01 : 8'h09;
            tbl[j].prs = e == 6 ? 8'h01 : e == 18 ? 8'h08 : 8'h00;
            tbl[j].rel = 8'h00;
            tbl[j].any = (e == 6 || e == 18);
            tbl[j].cnt = e < 7 ? 8'd0 : e < 19 ? 8'd1 : 8'd2;
        end
        m_reset();
        repeat (3) t(8'h00);
        rst_n = 1'b1;
        for (int j = 0; j < 19; j++) begin
            t(tbl[j].raw);
            chk("tbl_level", 0, o_lvl[0], tbl[j].lvl);
            chk("tbl_press", 0, o_prs[0], tbl[j].prs);
            chk("tbl_release", 0, o_rel[0], tbl[j].rel);
            chk("tbl_any", 0, {7'b0, o_any[0]}, {7'b0, tbl[j].any});
            chk("tbl_count", 0, o_cnt[0], tbl[j].cnt);
        end
        for (int k = 0; k < 10; k++) begin
            t(k < 2 ? 8'h08 : 8'h09);
            chk("glitch_level", 0, o_lvl[0], 8'h09);
            chk("glitch_release", 0, o_rel[0], 8'h00);
        end
        wait_pulse(8'h08, 1'b1, 8'h01, 6, "release");
        chk("release_level", 0, o_lvl[0], 8'h08);
        wait_pulse(8'hAC, 1'b0, 8'hA4, 6, "multi");
        chk("multi_any", 0, {7'b0, o_any[0]}, 8'h01);
        t(8'hAC);
        chk("multi_count", 0, o_cnt[0], 8'd5);
        repeat (8) t(8'h00);
        while (m_cnt[0] + 8 <= 254) begin
            repeat (8) t(8'hFF);
            repeat (8) t(8'h00);
        end
        while (m_cnt[0] < 254) begin
            repeat (8) t(8'h01);
            repeat (8) t(8'h00);
        end
        chk("preload", 0, o_cnt[0], 8'd254);
        repeat (8) t(8'h03);
        chk("saturate", 0, o_cnt[0], 8'd255);
        repeat (8) t(8'h00);
        repeat (8) t(8'h01);
        chk("sat_hold", 0, o_cnt[0], 8'd255);
        repeat (8) t(8'h00);
        wait_pulse(8'h01, 1'b0, 8'h01, 6, "clr_press");
        clr = 1'b1;
        t(8'h01);
        clr = 1'b0;
        chk("clr_priority", 0, o_cnt[0], 8'd0);
        t(8'h01);
        chk("clr_after", 0, o_cnt[0], 8'd0);
        en = 1'b0;
        t(8'h01);
        chk("en_off_level", 0, o_lvl[0], 8'h00);
        chk("en_off_release", 0, o_rel[0], 8'h00);
        t(8'h01);
        en = 1'b1;
        wait_pulse(8'h01, 1'b0, 8'h01, 4, "en_rise");
        repeat (8) t(8'h00);
        repeat (3) t(8'h01);
        #2 rst_n = 1'b0;
        #1 m_reset();
        for (int d = 0; d < 2; d++) begin
            chk("async_rst_level", d, o_lvl[d], 8'h00);
            chk("async_rst_press", d, o_prs[d], 8'h00);
            chk("async_rst_count", d, o_cnt[d], 8'h00);
        end
        t(8'h01);
        rst_n = 1'b1;
        wait_pulse(8'h01, 1'b0, 8'h01, 6, "post_rst");
        r0 = 8'h00;
        r1 = 8'hFF;
        repeat (2000) begin
            r0 ^= 8'($urandom & $urandom & $urandom);
            r1 ^= 8'($urandom & $urandom & $urandom);
            en = ($urandom_range(63) != 0);
            clr = ($urandom_range(63) == 0);
            tick(r0, r1);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
